// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the register file: round-robin arbitration among
// NUM_REQ valid/ready requesters, plus a sequencer that clears every entry.
module regfile_wr_arbiter #(
   parameter int unsigned   NUM_REQ     = 4,
   parameter int unsigned   AW          = 5,
   parameter int unsigned   DW          = 8,
   parameter logic [DW-1:0] CLEAR_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic                  clr_done,
   output logic                  rf_we,
   output logic [AW-1:0]         rf_waddr,
   output logic [DW-1:0]         rf_wdata
);

   localparam int unsigned   PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [AW-1:0] LAST_ADDR = '1;

   typedef enum logic {ARB, CLEAR} state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [AW-1:0] cnt;

   logic [AW-1:0] addr_arr [NUM_REQ];
   logic [DW-1:0] data_arr [NUM_REQ];

   logic          any_grant;
   logic [PW-1:0] win;
   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i] = req_addr[i*AW +: AW];
      assign data_arr[i] = req_data[i*DW +: DW];
   end

   // Rotating search starting at ptr; first valid requester wins.
   always_comb begin
      req_ready = '0;
      any_grant = 1'b0;
      win       = '0;
      sum       = '0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NUM_REQ)) begin
            sum = sum - (PW+1)'(NUM_REQ);
         end
         idx = sum[PW-1:0];
         if (!any_grant && req_valid[idx]) begin
            any_grant = 1'b1;
            win       = idx;
         end
      end
      if (rst || state != ARB || clr_start) begin
         any_grant = 1'b0;
      end
      if (any_grant) begin
         req_ready[win] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB;
         ptr      <= '0;
         cnt      <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         case (state)
            ARB: begin
               if (clr_start) begin
                  state    <= CLEAR;
                  cnt      <= '0;
                  clr_busy <= 1'b1;
                  rf_we    <= 1'b1;
                  rf_waddr <= '0;
                  rf_wdata <= CLEAR_VALUE;
               end else if (any_grant) begin
                  rf_we    <= 1'b1;
                  rf_waddr <= addr_arr[win];
                  rf_wdata <= data_arr[win];
                  ptr      <= (win == PW'(NUM_REQ-1)) ? '0 : win + 1'b1;
               end else begin
                  rf_we    <= 1'b0;
               end
            end
            CLEAR: begin
               // Stop after the last address is written; no wrap-around write.
               if (cnt == LAST_ADDR) begin
                  state    <= ARB;
                  rf_we    <= 1'b0;
                  clr_busy <= 1'b0;
                  clr_done <= 1'b1;
               end else begin
                  cnt      <= cnt + 1'b1;
                  rf_waddr <= cnt + 1'b1;
                  rf_we    <= 1'b1;
                  rf_wdata <= CLEAR_VALUE;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter against a queue-based reference model.
module tb_regfile_wr_arbiter;

   localparam int N  = 4;
   localparam int AW = 5;
   localparam int DW = 8;
   localparam logic [DW-1:0] CLR = 8'h00;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            clr_start;
   logic            clr_busy;
   logic            clr_done;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [DW-1:0]   rf_wdata;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int            m_ptr = 0;
   logic          m_we = 1'b0, m_busy = 1'b0, m_done = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   logic [AW-1:0] clrq [$];

   regfile_wr_arbiter #(
      .NUM_REQ(N), .AW(AW), .DW(DW), .CLEAR_VALUE(CLR)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .clr_start(clr_start),
      .clr_busy(clr_busy), .clr_done(clr_done),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   function automatic int winner();
      int w;
      w = -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (w < 0 && req_valid[i]) w = i;
      end
      return w;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] g;
      int w;
      g = '0;
      w = winner();
      if (!rst && !m_busy && !clr_start && w >= 0) g[w] = 1'b1;
      return g;
   endfunction

   function automatic logic [15:0] obs_out();
      return {rf_we, rf_waddr, rf_wdata, clr_busy, clr_done};
   endfunction

   function automatic logic [15:0] exp_out();
      return {m_we, m_addr, m_data, m_busy, m_done};
   endfunction

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      int w;
      if (rst) begin
         m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
         m_busy = 1'b0; m_done = 1'b0;
         clrq.delete();
      end else if (m_busy) begin
         m_done = 1'b0;
         if (clrq.size() > 0) begin
            m_addr = clrq.pop_front();
            m_we   = 1'b1;
            m_data = CLR;
         end else begin
            m_we = 1'b0; m_busy = 1'b0; m_done = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (clr_start) begin
            for (int a = 0; a < (1 << AW); a++) clrq.push_back(AW'(a));
            m_addr = clrq.pop_front();
            m_we   = 1'b1;
            m_data = CLR;
            m_busy = 1'b1;
         end else begin
            w = winner();
            if (w >= 0) begin
               m_we   = 1'b1;
               m_addr = req_addr[w*AW +: AW];
               m_data = req_data[w*DW +: DW];
               m_ptr  = (w + 1) % N;
            end else begin
               m_we = 1'b0;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rand_payload();
      req_addr = (N*AW)'($urandom);
      req_data = (N*DW)'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; clr_start = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 4'b1111; clr_start = 1'b1;
      rand_payload();
      repeat (2) begin
         #1;
         tests++;
         if (req_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_ready got %b exp 0000", req_ready);
         end
         tick();
         tests++;
         if (obs_out() !== 16'h0000) begin
            fails++; $display("FAIL reset_outputs got %h exp 0000", obs_out());
         end
      end
      rst = 1'b0; req_valid = '0; clr_start = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      rand_payload();
      req_valid = 4'b0100;
      req_addr[2*AW +: AW] = 5'd3;
      req_data[2*DW +: DW] = 8'hA5;
      #1;
      tests++;
      if (req_ready !== 4'b0100) begin
         fails++; $display("FAIL single_ready got %b exp 0100", req_ready);
      end
      tick();
      tests++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 8'hA5}) begin
         fails++; $display("FAIL single_write got %b/%0d/%h exp 1/3/a5", rf_we, rf_waddr, rf_wdata);
      end
      req_valid = '0;
      tick();
      tests++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 8'hA5}) begin
         fails++; $display("FAIL single_hold got %b/%0d/%h exp 0/3/a5", rf_we, rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] seq [5];
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW] = AW'(i + 7);
         req_data[i*DW +: DW] = DW'(8'h30 + i);
      end
      for (int c = 0; c < 5; c++) begin
         #1;
         tests++;
         if (req_ready !== seq[c]) begin
            fails++; $display("FAIL rr_ready[%0d] got %b exp %b", c, req_ready, seq[c]);
         end
         tick();
         tests++;
         if (obs_out() !== exp_out() || rf_we !== 1'b1) begin
            fails++; $display("FAIL rr_write[%0d] got %h exp %h", c, obs_out(), exp_out());
         end
      end
      req_valid = '0;
   endtask

   task automatic test_wrap();
      do_reset();
      rand_payload();
      req_valid = 4'b0010;
      #1;
      tests++;
      if (req_ready !== 4'b0010) begin
         fails++; $display("FAIL wrap_first got %b exp 0010", req_ready);
      end
      tick();
      req_valid = 4'b0011;
      #1;
      tests++;
      if (req_ready !== 4'b0001) begin
         fails++; $display("FAIL wrap_ready got %b exp 0001", req_ready);
      end
      tick();
      tests++;
      if (rf_we !== 1'b1 || rf_waddr !== req_addr[AW-1:0] || rf_wdata !== req_data[DW-1:0]) begin
         fails++; $display("FAIL wrap_write got %h exp %h", obs_out(), exp_out());
      end
      req_valid = '0;
   endtask

   task automatic test_clear();
      int busy_cnt, done_cnt, done_at;
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      req_valid = 4'b1111; clr_start = 1'b1;
      rand_payload();
      for (int c = 0; c < 34; c++) begin
         #1;
         tests++;
         if (req_ready !== exp_ready() || (c <= 32 && req_ready !== '0) || (c == 33 && req_ready === '0)) begin
            fails++; $display("FAIL clear_ready[T+%0d] got %b exp %b", c, req_ready, exp_ready());
         end
         tick();
         tests++;
         if (obs_out() !== exp_out()) begin
            fails++; $display("FAIL clear_out[T+%0d] got %h exp %h", c + 1, obs_out(), exp_out());
         end
         if (clr_busy === 1'b1) busy_cnt++;
         if (clr_done === 1'b1) begin done_cnt++; done_at = c + 1; end
         rand_payload();
         clr_start = (c < 30) ? 1'($urandom) : 1'b0;
      end
      tests++;
      if (busy_cnt != 32 || done_cnt != 1 || done_at != 33) begin
         fails++; $display("FAIL clear_timing got busy=%0d done=%0d at=%0d exp 32/1/33", busy_cnt, done_cnt, done_at);
      end
      req_valid = '0; clr_start = 1'b0;
   endtask

   task automatic test_clear_reset();
      int done_cnt;
      done_cnt = 0;
      do_reset();
      req_valid = '0; clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      repeat (10) tick();
      tests++;
      if (rf_waddr !== 5'd10 || clr_busy !== 1'b1) begin
         fails++; $display("FAIL clrrst_pos got addr=%0d busy=%b exp 10/1", rf_waddr, clr_busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if ({rf_we, clr_busy, clr_done} !== 3'b000 || obs_out() !== exp_out()) begin
         fails++; $display("FAIL clrrst_abort got %h exp %h", obs_out(), exp_out());
      end
      for (int c = 0; c < 40; c++) begin
         tick();
         if (clr_done === 1'b1) done_cnt++;
         tests++;
         if (obs_out() !== exp_out() || rf_we !== 1'b0) begin
            fails++; $display("FAIL clrrst_idle[%0d] got %h exp %h", c, obs_out(), exp_out());
         end
      end
      tests++;
      if (done_cnt != 0) begin
         fails++; $display("FAIL clrrst_done got %0d pulses exp 0", done_cnt);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 149) == 0);
         clr_start = ($urandom_range(0, 59) == 0);
         req_valid = N'($urandom);
         rand_payload();
         #1;
         tests++;
         if (req_ready !== exp_ready()) begin
            fails++; $display("FAIL rand_ready[%0d] got %b exp %b", c, req_ready, exp_ready());
         end
         tick();
         tests++;
         if (obs_out() !== exp_out()) begin
            fails++; $display("FAIL rand_out[%0d] got %h exp %h", c, obs_out(), exp_out());
         end
      end
      rst = 1'b0; clr_start = 1'b0; req_valid = '0;
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; clr_start = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_clear();
      test_clear_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
